// File: rtl/mem_requester.sv
// Bus-master side of the 8-bit RAM en/read/write/ready handshake: one request in, one response out.
// Out-of-range addresses are rejected without touching the RAM, and a ready timeout bounds every access.
module mem_requester #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 128,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W makes every address legal.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        tcnt_r;
  logic [7:0]        tcnt_nxt_s;
  logic              in_range_s;
  logic              timeout_s;

  logic              req_ready_nxt_s;
  logic              resp_valid_nxt_s;
  logic [DATA_W-1:0] resp_rdata_nxt_s;
  logic              resp_err_nxt_s;
  logic              busy_nxt_s;
  logic              mem_en_nxt_s;
  logic              mem_read_nxt_s;
  logic              mem_write_nxt_s;
  logic [ADDR_W-1:0] mem_address_nxt_s;
  logic [DATA_W-1:0] mem_wdata_nxt_s;

  assign in_range_s = ({1'b0, req_addr} < DEPTH_L);
  // Ready on the same edge as the last allowed wait wins over the timeout.
  assign timeout_s  = !mem_ready && (tcnt_r == TO_LAST);

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      tcnt_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
    end
  end

  // Next-state and timeout count.
  always_comb begin
    state_nxt_s = state_r;
    tcnt_nxt_s  = tcnt_r;
    case (state_r)
      IDLE: begin
        tcnt_nxt_s = 8'd0;
        if (req_valid) begin
          state_nxt_s = in_range_s ? ACCESS : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready || timeout_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCESS;
          tcnt_nxt_s  = tcnt_r + 8'd1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        tcnt_nxt_s  = 8'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        tcnt_nxt_s  = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs; RAM port and response fields hold unless updated.
  always_comb begin
    resp_valid_nxt_s  = 1'b0;
    resp_rdata_nxt_s  = resp_rdata;
    resp_err_nxt_s    = resp_err;
    mem_en_nxt_s      = mem_en;
    mem_read_nxt_s    = mem_read;
    mem_write_nxt_s   = mem_write;
    mem_address_nxt_s = mem_address;
    mem_wdata_nxt_s   = mem_wdata;
    req_ready_nxt_s   = (state_nxt_s == IDLE);
    busy_nxt_s        = (state_nxt_s != IDLE);
    case (state_r)
      IDLE: begin
        if (req_valid && in_range_s) begin
          mem_en_nxt_s      = 1'b1;
          mem_read_nxt_s    = !req_write;
          mem_write_nxt_s   = req_write;
          mem_address_nxt_s = req_addr;
          mem_wdata_nxt_s   = req_wdata;
        end else if (req_valid) begin
          resp_valid_nxt_s = 1'b1;
          resp_err_nxt_s   = 1'b1;
          resp_rdata_nxt_s = {DATA_W{1'b0}};
        end else begin
          mem_en_nxt_s = 1'b0;
        end
      end
      ACCESS: begin
        if (mem_ready || timeout_s) begin
          mem_en_nxt_s     = 1'b0;
          mem_read_nxt_s   = 1'b0;
          mem_write_nxt_s  = 1'b0;
          resp_valid_nxt_s = 1'b1;
          resp_err_nxt_s   = !mem_ready;
          resp_rdata_nxt_s = (mem_ready && mem_read) ? mem_rdata : {DATA_W{1'b0}};
        end else begin
          mem_en_nxt_s = 1'b1;
        end
      end
      DONE: begin
        mem_en_nxt_s    = 1'b0;
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
      end
      default: begin
        mem_en_nxt_s    = 1'b0;
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops the RAM enable immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= {DATA_W{1'b0}};
      resp_err    <= 1'b0;
      busy        <= 1'b0;
      mem_en      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
    end else begin
      req_ready   <= req_ready_nxt_s;
      resp_valid  <= resp_valid_nxt_s;
      resp_rdata  <= resp_rdata_nxt_s;
      resp_err    <= resp_err_nxt_s;
      busy        <= busy_nxt_s;
      mem_en      <= mem_en_nxt_s;
      mem_read    <= mem_read_nxt_s;
      mem_write   <= mem_write_nxt_s;
      mem_address <= mem_address_nxt_s;
      mem_wdata   <= mem_wdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: a standard RAM (ready one edge after enable is seen) plus a
// request-level reference model predicting response data, error flag, latency and enable length.
module tb_mem_requester;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_err, busy;
  logic [7:0] resp_rdata;
  logic       mem_en, mem_read, mem_write;
  logic [7:0] mem_address, mem_wdata, mem_rdata;
  logic       mem_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [0:127];
  logic [7:0] ref_mem [0:127];
  logic [1:0] ram_cnt;
  logic       ram_dead = 1'b0;

  mem_requester dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_init(input int i);
    if (i == 7) return 8'd32;
    return 8'(i * 37 + 11);
  endfunction

  // RAM environment: counts enabled edges, raises ready on the second, clears when enable drops.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 128; i++) ram[i] <= ram_init(i);
      ram_cnt   <= 2'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 8'd0;
    end else if (!mem_en || ram_dead) begin
      ram_cnt   <= 2'd0;
      mem_ready <= 1'b0;
    end else if (ram_cnt == 2'd0) begin
      ram_cnt <= 2'd1;
    end else if (!mem_ready) begin
      mem_ready <= 1'b1;
      if (mem_write) ram[mem_address[6:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_address[6:0]];
    end
  end

  // Reference model: outcome of one request from the address map, RAM health and memory contents.
  task automatic model_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output int e_lat, output int e_en, output logic [7:0] e_rd, output logic e_err);
    if (a >= 8'd128) begin
      e_lat = 0; e_en = 0; e_rd = 8'd0; e_err = 1'b1;
    end else if (ram_dead) begin
      e_lat = 15; e_en = 15; e_rd = 8'd0; e_err = 1'b1;
    end else begin
      e_lat = 3; e_en = 3; e_err = 1'b0;
      e_rd = w ? 8'd0 : ref_mem[a[6:0]];
      if (w) ref_mem[a[6:0]] = d;
    end
  endtask

  // Drives one request and observes: edge of resp_valid after accept, enable cycles, port sanity.
  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output int en_cnt, output logic [7:0] rd,
                        output logic er, output logic bad_port);
    int guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    lat = -1; en_cnt = 0; rd = 8'd0; er = 1'b0; bad_port = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (mem_en) begin
        en_cnt++;
        if (mem_address !== a || mem_write !== w || mem_read !== !w || (w && mem_wdata !== d)) bad_port = 1'b1;
      end
      if (mem_read && mem_write) bad_port = 1'b1;
      if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; break; end
    end
  endtask

  task automatic test_reset;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'd0; req_wdata = 8'd0;
    reset_n = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = ram_init(i);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, busy, mem_en, mem_read, mem_write} !== 7'b1000000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000000",
        {req_ready, resp_valid, resp_err, busy, mem_en, mem_read, mem_write});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_wdata} !== 24'd0) begin
      errors++; $display("FAIL reset_buses: got %h expected 000000", {resp_rdata, mem_address, mem_wdata});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    int lat, en_cnt, e_lat, e_en; logic [7:0] rd, e_rd; logic er, e_err, bad;
    model_req(1'b0, 8'd7, 8'd0, e_lat, e_en, e_rd, e_err);
    do_req(1'b0, 8'd7, 8'd0, lat, en_cnt, rd, er, bad);
    checks++; if (lat !== e_lat) begin errors++; $display("FAIL load_latency: got %0d expected %0d", lat, e_lat); end
    checks++; if (en_cnt !== e_en) begin errors++; $display("FAIL load_en_cycles: got %0d expected %0d", en_cnt, e_en); end
    checks++; if (rd !== 8'd32) begin errors++; $display("FAIL load_rdata: got %0d expected 32", rd); end
    checks++; if (er !== e_err) begin errors++; $display("FAIL load_err: got %b expected %b", er, e_err); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL load_port: got bad=%b expected 0", bad); end
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL load_done_state: got ready=%b busy=%b expected 0 1", req_ready, busy); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 8'd32) begin
      errors++; $display("FAIL load_idle_state: got ready=%b busy=%b valid=%b rdata=%0d expected 1 0 0 32",
        req_ready, busy, resp_valid, resp_rdata); end
  endtask

  task automatic test_store_load;
    int lat, en_cnt, e_lat, e_en; logic [7:0] rd, e_rd; logic er, e_err, bad;
    logic wl [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      model_req(wl[k], 8'd40, 8'hA5, e_lat, e_en, e_rd, e_err);
      do_req(wl[k], 8'd40, 8'hA5, lat, en_cnt, rd, er, bad);
      checks++; if (lat !== e_lat || en_cnt !== e_en) begin errors++;
        $display("FAIL store_load_timing[%0d]: got lat=%0d en=%0d expected %0d %0d", k, lat, en_cnt, e_lat, e_en); end
      checks++; if (rd !== e_rd || er !== e_err) begin errors++;
        $display("FAIL store_load_resp[%0d]: got rdata=%h err=%b expected %h %b", k, rd, er, e_rd, e_err); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL store_load_port[%0d]: got bad=%b expected 0", k, bad); end
    end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL store_load_value: got %h expected a5", rd); end
  endtask

  task automatic test_range;
    int lat, en_cnt, e_lat, e_en; logic [7:0] rd, e_rd; logic er, e_err, bad;
    logic [7:0] al [4] = '{8'd200, 8'd128, 8'd255, 8'd127};
    for (int k = 0; k < 4; k++) begin
      model_req(1'b0, al[k], 8'd0, e_lat, e_en, e_rd, e_err);
      do_req(1'b0, al[k], 8'd0, lat, en_cnt, rd, er, bad);
      checks++; if (lat !== e_lat || en_cnt !== e_en) begin errors++;
        $display("FAIL range_timing[%0d]: got lat=%0d en=%0d expected %0d %0d", al[k], lat, en_cnt, e_lat, e_en); end
      checks++; if (rd !== e_rd || er !== e_err) begin errors++;
        $display("FAIL range_resp[%0d]: got rdata=%h err=%b expected %h %b", al[k], rd, er, e_rd, e_err); end
    end
  endtask

  task automatic test_timeout;
    int lat, en_cnt, e_lat, e_en; logic [7:0] rd, e_rd; logic er, e_err, bad;
    ram_dead = 1'b1;
    model_req(1'b0, 8'd50, 8'd0, e_lat, e_en, e_rd, e_err);
    do_req(1'b0, 8'd50, 8'd0, lat, en_cnt, rd, er, bad);
    checks++; if (lat !== e_lat) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, e_lat); end
    checks++; if (en_cnt !== e_en) begin errors++; $display("FAIL timeout_en_cycles: got %0d expected %0d", en_cnt, e_en); end
    checks++; if (rd !== e_rd || er !== e_err) begin errors++;
      $display("FAIL timeout_resp: got rdata=%h err=%b expected %h %b", rd, er, e_rd, e_err); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL timeout_en_drop: got %b expected 0", mem_en); end
    ram_dead = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] al [4] = '{8'd12, 8'd13, 8'd33, 8'd34};
    logic [7:0] exp_q [$];
    int acc [$];
    int e = 0, nacc = 0, nresp = 0, rises = 0, guard = 0;
    logic rr, pe;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = al[0];
    pe = mem_en;
    for (int k = 0; k < 40 && nresp < 4; k++) begin
      rr = req_ready;
      @(posedge clk); #1; e++;
      if (rr && req_valid) begin
        acc.push_back(e); exp_q.push_back(ref_mem[al[nacc][6:0]]); nacc++;
        if (nacc < 4) req_addr = al[nacc]; else req_valid = 1'b0;
      end
      if (mem_en && !pe) rises++;
      pe = mem_en;
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_resp: got response expected none"); end
        else begin
          logic [7:0] x = exp_q.pop_front();
          if (resp_rdata !== x || resp_err !== 1'b0) begin errors++;
            $display("FAIL b2b_resp[%0d]: got rdata=%h err=%b expected %h 0", nresp, resp_rdata, resp_err, x); end
        end
        nresp++;
      end
    end
    req_valid = 1'b0;
    checks++; if (nresp !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", nresp); end
    checks++; if (rises !== 4) begin errors++; $display("FAIL b2b_en_pulses: got %0d expected 4", rises); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++; if (acc[i] - acc[i-1] !== 5) begin errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d expected 5", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_random;
    int lat, en_cnt, e_lat, e_en; logic [7:0] rd, e_rd, a, d; logic er, e_err, bad, w;
    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      d = 8'($urandom);
      model_req(w, a, d, e_lat, e_en, e_rd, e_err);
      do_req(w, a, d, lat, en_cnt, rd, er, bad);
      checks++; if (lat !== e_lat || en_cnt !== e_en || bad !== 1'b0) begin errors++;
        $display("FAIL rand_timing[%0d]: got lat=%0d en=%0d bad=%b expected %0d %0d 0", k, lat, en_cnt, bad, e_lat, e_en); end
      checks++; if (rd !== e_rd || er !== e_err) begin errors++;
        $display("FAIL rand_resp[%0d]: got rdata=%h err=%b expected %h %b (w=%b a=%0d)", k, rd, er, e_rd, e_err, w, a); end
    end
  endtask

  task automatic test_reset_mid_access;
    int guard = 0; int seen = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_en: got %b expected 1", mem_en); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, busy, mem_en, mem_read, mem_write} !== 7'b1000000) begin
      errors++; $display("FAIL midrst_flags: got %b expected 1000000",
        {req_ready, resp_valid, resp_err, busy, mem_en, mem_read, mem_write});
    end
    checks++; if ({resp_rdata, mem_address} !== 16'd0) begin errors++;
      $display("FAIL midrst_buses: got %h expected 0000", {resp_rdata, mem_address}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (resp_valid) seen++; end
    checks++; if (seen !== 0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_no_resp: got resp=%0d ready=%b expected 0 1", seen, req_ready); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_load();
    test_range();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end
endmodule
